// File: rtl/arg_num_parser.sv
// Parses one signed decimal argument from an ASCII character stream into a
// saturating two's-complement value of width 2*MAX_ARG_BITS.
`ifndef OP_ARG_BITS
`define OP_ARG_BITS 12
`endif

module arg_num_parser #(
  parameter int  MAX_ARG_BITS = `OP_ARG_BITS,
  localparam int NUM_BITS     = 2 * MAX_ARG_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          char_in,
  input  logic                char_valid,
  output logic                char_ready,
  output logic [NUM_BITS-1:0] num_out,
  output logic                is_err,
  output logic                num_valid,
  input  logic                num_ready,
  output logic [1:0]          state_dbg
);

  // Handshakes: a character transfers on a rising edge where char_valid &&
  // char_ready; a result transfers on a rising edge where num_valid && num_ready.
  typedef enum logic [1:0] {IDLE, SIGN, DIGITS, DONE} state_t;

  localparam logic [NUM_BITS+3:0] MAG_MAX = {5'b0, {(NUM_BITS-1){1'b1}}};

  state_t              state;
  logic [NUM_BITS-2:0] mag;
  logic                neg;

  logic                is_digit;
  logic                is_term;
  logic                is_sign;
  logic [NUM_BITS+3:0] mag_wide;
  logic [NUM_BITS+3:0] mag_acc;
  logic [NUM_BITS-2:0] mag_next;
  logic [NUM_BITS-2:0] mag_first;
  logic [NUM_BITS-1:0] mag_ext;
  logic [NUM_BITS-1:0] result;

  assign is_digit  = (char_in >= 8'h30) && (char_in <= 8'h39);
  assign is_term   = (char_in == 8'h20) || (char_in == 8'h0A) || (char_in == 8'h0D);
  assign is_sign   = (char_in == 8'h2D) || (char_in == 8'h2B);

  // mag*10 + d, widened so the clamp comparison can never itself overflow.
  assign mag_wide  = {5'b0, mag};
  assign mag_acc   = (mag_wide << 3) + (mag_wide << 1) + {{NUM_BITS{1'b0}}, char_in[3:0]};
  assign mag_next  = (mag_acc > MAG_MAX) ? MAG_MAX[NUM_BITS-2:0] : mag_acc[NUM_BITS-2:0];
  assign mag_first = {{(NUM_BITS-5){1'b0}}, char_in[3:0]};

  assign mag_ext   = {1'b0, mag};
  assign result    = neg ? -mag_ext : mag_ext;

  assign char_ready = !reset && (state != DONE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mag       <= '0;
      neg       <= 1'b0;
      num_out   <= '0;
      is_err    <= 1'b0;
      num_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (char_valid) begin
            if (is_term) begin
              state <= IDLE;
            end else if (is_sign) begin
              neg   <= (char_in == 8'h2D);
              state <= SIGN;
            end else if (is_digit) begin
              mag   <= mag_first;
              state <= DIGITS;
            end else begin
              num_out   <= '0;
              is_err    <= 1'b1;
              num_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SIGN: begin
          if (char_valid) begin
            if (is_digit) begin
              mag   <= mag_first;
              state <= DIGITS;
            end else begin
              num_out   <= '0;
              is_err    <= 1'b1;
              num_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DIGITS: begin
          if (char_valid) begin
            if (is_digit) begin
              mag <= mag_next;
            end else begin
              num_out   <= is_term ? result : '0;
              is_err    <= !is_term;
              num_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (num_ready) begin
            num_valid <= 1'b0;
            mag       <= '0;
            neg       <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arg_num_parser.sv
// Directed bench for arg_num_parser: character strings in, result and
// handshake behaviour compared against hand-computed values.
module tb_arg_num_parser;

  logic        clk;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [23:0] num_out;
  logic        is_err;
  logic        num_valid;
  logic        num_ready;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  arg_num_parser dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .num_out    (num_out),
    .is_err     (is_err),
    .num_valid  (num_valid),
    .num_ready  (num_ready),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drives one character per cycle at negedges; returns at the negedge after the last edge.
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      char_in    = s[i];
      char_valid = 1'b1;
      check({"rdy_", s}, {31'b0, char_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    char_valid = 1'b0;
    char_in    = 8'h00;
  endtask

  // Checks the held result right after the terminator, then hands it off.
  task automatic take_result(input string tag, input logic [23:0] exp_num, input logic exp_err);
    check({tag, "_valid"}, {31'b0, num_valid}, 32'd1);
    check({tag, "_num"},   {8'b0, num_out},    {8'b0, exp_num});
    check({tag, "_err"},   {31'b0, is_err},    {31'b0, exp_err});
    check({tag, "_crdy0"}, {31'b0, char_ready}, 32'd0);
    num_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    num_ready = 1'b0;
    check({tag, "_vld0"},  {31'b0, num_valid}, 32'd0);
    check({tag, "_crdy1"}, {31'b0, char_ready}, 32'd1);
  endtask

  function automatic logic fits12(input logic [23:0] v);
    return ($signed(v) >= -24'sd2048) && ($signed(v) <= 24'sd2047);
  endfunction

  initial begin
    reset      = 1'b1;
    char_in    = 8'h00;
    char_valid = 1'b0;
    num_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, num_valid}, 32'd0);
    check("rst_num",   {8'b0, num_out},    32'd0);
    check("rst_err",   {31'b0, is_err},    32'd0);
    check("rst_crdy",  {31'b0, char_ready}, 32'd0);
    check("rst_state", {30'b0, state_dbg}, 32'd0);
    reset = 1'b0;
    #1;
    check("rel_crdy", {31'b0, char_ready}, 32'd1);
    @(negedge clk);

    send_str("123 ");
    check("fit_123", {31'b0, fits12(num_out)}, 32'd1);
    take_result("p123", 24'd123, 1'b0);

    send_str("-2048\n");
    check("fit_m2048", {31'b0, fits12(num_out)}, 32'd1);
    take_result("m2048", 24'hFFF800, 1'b0);
    send_str("2048 ");
    check("fit_2048", {31'b0, fits12(num_out)}, 32'd0);
    take_result("p2048", 24'd2048, 1'b0);

    send_str("9999999999 ");
    take_result("sat_pos", 24'h7FFFFF, 1'b0);
    send_str("-9999999999 ");
    take_result("sat_neg", 24'h800001, 1'b0);

    send_str("- ");
    take_result("err_sign", 24'd0, 1'b1);
    send_str("1a");
    take_result("err_digit", 24'd0, 1'b1);
    send_str("x");
    take_result("err_idle", 24'd0, 1'b1);
    send_str("  7 ");
    take_result("lead_ws", 24'd7, 1'b0);
    send_str("+-");
    take_result("err_2sign", 24'd0, 1'b1);
    send_str("-0 ");
    take_result("neg_zero", 24'd0, 1'b0);
    send_str("+0050\r");
    take_result("plus_lz", 24'd50, 1'b0);

    // Result held while the consumer stalls.
    send_str("42\r");
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'b0, num_valid}, 32'd1);
      check("hold_num",   {8'b0, num_out},    32'd42);
      check("hold_crdy",  {31'b0, char_ready}, 32'd0);
      @(negedge clk);
    end
    take_result("hold", 24'd42, 1'b0);

    // num_ready without a pending result does nothing.
    num_ready = 1'b1;
    @(negedge clk);
    num_ready = 1'b0;
    check("idle_rdy_vld",  {31'b0, num_valid}, 32'd0);
    check("idle_rdy_crdy", {31'b0, char_ready}, 32'd1);

    // Reset mid-number discards the partial value.
    send_str("45");
    reset = 1'b1;
    #1;
    check("mid_rst_crdy", {31'b0, char_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_state", {30'b0, state_dbg}, 32'd0);
    @(negedge clk);
    send_str("7 ");
    take_result("after_rst", 24'd7, 1'b0);

    // Reset while a result is pending.
    send_str("8 ");
    check("pend_valid", {31'b0, num_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("done_rst_vld", {31'b0, num_valid}, 32'd0);
    check("done_rst_num", {8'b0, num_out},    32'd0);
    check("done_rst_err", {31'b0, is_err},    32'd0);
    @(negedge clk);
    check("done_rst_crdy", {31'b0, char_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
